// File: rtl/rr_mux_arbiter.sv
// Purpose : four-way round-robin arbiter feeding a single-entry registered 4:1 output stage.
// Latency : word captured at edge N is on out_data/out_valid after edge N (1 cycle).
// Backpr. : when FULL and out_ready=0 nothing is acked; load again as the old word leaves.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   req[3:0]       per-requester valid; din[k*WIDTH +: WIDTH] is requester k's word
//   ack[3:0]       one-hot combinational grant, high in the cycle the word is captured
//   sel, out_valid, out_data   registered output stage (sel = source index)
//   out_ready      downstream accepts out_data this cycle
//   busy           out_valid | (|req)
module rr_mux_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] din,
    output logic [3:0]         ack,
    output logic [1:0]         sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    input  logic               out_ready,
    output logic               busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [1:0]       ptr;
    logic [1:0]       grant;
    logic             load;
    logic             any_req;
    logic [WIDTH-1:0] din_arr [4];

    assign any_req   = |req;
    assign out_valid = (state == FULL);
    assign busy      = out_valid | any_req;

    // rst is part of load so ack drops the moment reset asserts, not at the next edge.
    assign load = (!out_valid || out_ready) && any_req && !rst;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            din_arr[k] = din[k*WIDTH +: WIDTH];
        end
    end

    // Walk the search order from the far end back towards ptr so the
    // requester closest to ptr (lowest offset) is the one left in grant.
    always_comb begin
        logic [1:0] idx;
        grant = ptr;
        idx   = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

    always_comb begin
        ack = 4'b0000;
        if (load) begin
            ack[grant] = 1'b1;
        end
    end

    // Output-register occupancy; a concurrent handshake and load keeps FULL.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (load) state_next = FULL;
            FULL:  if (out_ready && !any_req) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and pointer only move on a load; a draining handshake leaves them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            sel      <= 2'd0;
            ptr      <= 2'd0;
        end else if (load) begin
            out_data <= din_arr[grant];
            sel      <= grant;
            ptr      <= grant + 2'd1;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst;
    logic [3:0]         req;
    logic [4*WIDTH-1:0] din;
    logic [3:0]         ack;
    logic [1:0]         sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;
    logic               busy;

    rr_mux_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .ack       (ack),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: occupancy flag, stored word, source index, next search start.
    bit       m_valid;
    int       m_data;
    int       m_sel;
    int       m_ptr;
    logic [3:0] last_ack;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic int model_grant(input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (r[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_data  = 0;
        m_sel   = 0;
        m_ptr   = 0;
    endtask

    // One cycle: drive at negedge, check combinational outputs, clock, check registers.
    task automatic step(input logic [3:0] r, input logic [31:0] d, input logic rdy);
        int         g;
        bit         ld;
        logic [3:0] eack;
        req       = r;
        din       = d;
        out_ready = rdy;
        #1;
        ld   = (!m_valid || rdy) && (r != 4'b0000);
        g    = model_grant(r);
        eack = 4'b0000;
        if (ld) eack[g] = 1'b1;
        chk("ack", {28'd0, ack}, {28'd0, eack});
        chk("busy", {31'd0, busy}, {31'd0, (m_valid || r != 4'b0000)});
        last_ack = ack;
        @(posedge clk);
        if (ld) begin
            m_valid = 1;
            m_data  = (d >> (8 * g)) & 8'hFF;
            m_sel   = g;
            m_ptr   = (g + 1) % 4;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_data", {24'd0, out_data}, m_data);
        chk("sel", {30'd0, sel}, m_sel);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rr_din;
        logic [7:0]  bp_data;
        int          cnt;

        rst = 1'b1; req = 4'b0000; din = '0; out_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_sel", {30'd0, sel}, 32'd0);
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin with all requesters active
        rr_din = 32'h13121110;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] exp_ack;
            step(4'b1111, rr_din, 1'b1);
            exp_ack = 4'b0001 << (i % 4);
            chk("rr_ack", {28'd0, last_ack}, {28'd0, exp_ack});
            chk("rr_data", {24'd0, out_data}, 32'h10 + (i % 4));
        end
        step(4'b0000, 32'd0, 1'b1);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // Single requester
        step(4'b0100, 32'h005A0000, 1'b1);
        chk("single_ack", {28'd0, last_ack}, 32'h4);
        chk("single_data", {24'd0, out_data}, 32'h5A);
        chk("single_sel", {30'd0, sel}, 32'd2);
        step(4'b0000, 32'd0, 1'b1);
        chk("single_drop", {31'd0, out_valid}, 32'd0);

        // Wrap and skip: ptr is now 3
        step(4'b1001, 32'hC00000C3, 1'b1);
        chk("wrap_g3", {28'd0, last_ack}, 32'h8);
        step(4'b0001, 32'h000000C0, 1'b1);
        chk("wrap_g0", {28'd0, last_ack}, 32'h1);

        // Backpressure: fill, stall 3 cycles, release
        step(4'b0011, 32'h0000B2B1, 1'b1);
        bp_data = out_data;
        for (int i = 0; i < 3; i++) begin
            step(4'b0011, 32'h0000B2B1, 1'b0);
            chk("bp_ack", {28'd0, last_ack}, 32'h0);
            chk("bp_hold", {24'd0, out_data}, {24'd0, bp_data});
        end
        step(4'b0011, 32'h0000B2B1, 1'b1);
        chk("bp_release_ack", {28'd0, last_ack}, 32'h1);
        chk("bp_release_data", {24'd0, out_data}, 32'hB1);
        chk("bp_no_bubble", {31'd0, out_valid}, 32'd1);

        // Mid-operation asynchronous reset from FULL with A5 on channel 2
        step(4'b0100, 32'h00A50000, 1'b1);
        step(4'b0000, 32'd0, 1'b0);
        chk("pre_rst_data", {24'd0, out_data}, 32'hA5);
        req = 4'b1111; din = 32'h33221100; out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_data", {24'd0, out_data}, 32'd0);
        chk("arst_sel", {30'd0, sel}, 32'd0);
        chk("arst_ack", {28'd0, ack}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        step(4'b1111, 32'h33221100, 1'b1);
        chk("post_rst_grant", {28'd0, last_ack}, 32'h1);

        // Randomised traffic with random backpressure
        for (int i = 0; i < 200; i++) begin
            step(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
        end

        // Starvation: requester 3 always asserted, others random
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step({1'b1, 3'($urandom_range(0, 7))}, $urandom, 1'b1);
            if (last_ack[3]) cnt = 0;
            else if (last_ack != 4'b0000) cnt++;
            chk("starve_bound", {31'd0, (cnt < 4)}, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Four-requester round-robin arbiter and single-entry output register that shares one WIDTH-bit channel between four sources. It chooses one requester per transfer, drives the 4:1 select, and captures the chosen data word into a registered output stage. The downstream side uses a valid/ready handshake. It sits in front of the 4:1 multiplexer datapath and turns it into a fair, flow-controlled shared resource.

## Interface
- WIDTH, 8, data width of each requester and of the output
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  per-requester valid; req[k] means din[k] holds a word to send
- din  input  4*WIDTH  requester data; din[k] is bits [k*WIDTH +: WIDTH]
- ack  output  4  one-hot, combinational; ack[k] high means din[k] is captured at this rising edge
- sel  output  2  index of the requester whose word is in out_data (registered)
- out_valid  output  1  out_data holds a word (registered)
- out_data  output  WIDTH  captured word (registered)
- out_ready  input  1  downstream accepts out_data this cycle
- busy  output  1  combinational, equal to out_valid | (|req)

## Operation
- Output register has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- load = (!out_valid | out_ready) & (|req) & !rst.
- Grant g: the first k with req[k]=1 in search order ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- ptr is an internal 2-bit round-robin pointer.
- ack = load ? onehot(g) : 4'b0000. At most one bit is set, and it is set only where req is set.
- On the load edge: out_data <= din[g], sel <= g, out_valid <= 1, ptr <= (g+1) mod 4. The pointer wraps 3 -> 0.
- Handshake with no load: if out_valid & out_ready & !(|req), then out_valid <= 0. out_data and sel hold their values.
- No handshake: if out_valid & !out_ready, out_data, sel and ptr hold, and ack=0.
- State transitions:
  - EMPTY -> FULL on load.
  - FULL -> FULL when out_ready=0, or when a handshake and a load happen together.
  - FULL -> EMPTY on a handshake with no req.
- Requester protocol: hold req[k] and din[k] stable until ack[k]. If req[k] is still high in the cycle after ack[k], that is a new word.
- Fairness: a requester that holds req is granted within 4 loads.

## Timing
- Reset values:
  - out_valid=0, out_data=0, sel=0, ptr=0.
  - ack=0 while rst is high.
  - busy follows req.
- Latency: a word captured at edge N appears on out_data with out_valid=1 in the cycle after edge N. Capture to output takes 1 cycle.
- Throughput: with out_ready held at 1, one word per cycle and no bubbles.
- Simultaneous handshake and load: the new word replaces the old one at the same edge, and out_valid stays 1.
- A req that drops before its ack is ignored. The pointer does not move.
- Reset in mid-operation: a pending word is discarded, ptr returns to 0, and ack is forced to 0 at once (asynchronous).
- After rst is released, the first grant is chosen from ptr=0.

## Test plan
- Reset: FULL with out_data=0xA5 and sel=2, then pulse rst asynchronously -> out_valid=0, out_data=0, sel=0, ack=0 immediately. The next grant with req=1111 goes to 0.
- Single requester: req=0100, din[2]=0x5A, out_ready=1 -> ack=0100 that cycle. Next cycle out_valid=1, out_data=0x5A, sel=2. With req dropped, out_valid=0 one cycle later.
- Round-robin: req=1111 held, out_ready=1, din[k]=0x10+k -> out_data sequence 0x10, 0x11, 0x12, 0x13, 0x10 on consecutive cycles. ack rotates 0001, 0010, 0100, 1000, 0001.
- Backpressure: FULL, out_ready=0 for 3 cycles with req=0011 -> ack=0000 and out_data stable. Raise out_ready -> ack asserts that cycle, and the new word appears next cycle with no bubble.
- Wrap and skip: after a grant to 2 (ptr=3), req=1001 -> grant 3, then grant 0.
- Starvation check: req[3] held and req[0..2] toggling randomly, out_ready=1 -> ack[3] within 4 loads.
